// File: rtl/fetch_redirect_if.sv
// Fetch-side bundle: branch redirect, instruction-memory read channel and decode handshake.
// FETCH_MISALIGN_CHK_EN adds the sticky fetch_misaligned flag.
interface fetch_redirect_if #(
  parameter int PC_W = 9
);
  logic            PcSel;
  logic [31:0]     BrPC;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            if_valid;
  logic            if_ready;
  logic [PC_W-1:0] if_pc;
  logic [31:0]     if_instr;
`ifdef FETCH_MISALIGN_CHK_EN
  logic            fetch_misaligned;
`endif

  modport master (
    input  PcSel, BrPC, imem_ready, imem_rvalid, imem_rdata, if_ready,
`ifdef FETCH_MISALIGN_CHK_EN
    output fetch_misaligned,
`endif
    output imem_req, imem_addr, if_valid, if_pc, if_instr
  );

  modport slave (
    output PcSel, BrPC, imem_ready, imem_rvalid, imem_rdata, if_ready,
`ifdef FETCH_MISALIGN_CHK_EN
    input  fetch_misaligned,
`endif
    input  imem_req, imem_addr, if_valid, if_pc, if_instr
  );
endinterface

// File: rtl/fetch_redirect_unit.sv
// IF stage: owns the fetch PC, keeps one imem read in flight, buffers {pc,instr} for decode,
// and flushes/restarts on a branch redirect. FETCH_MISALIGN_CHK_EN halts fetch on misaligned targets.
module fetch_redirect_unit #(
  parameter int              PC_W     = 9,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic             clk,
  input logic             reset,
  fetch_redirect_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {FETCH, WAIT, DROP} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            empty, full, halt, accept, push, pop;
  logic [PC_W-1:0] target;
  logic            unused_brpc;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign target      = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unused_brpc = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

`ifdef FETCH_MISALIGN_CHK_EN
  logic misaligned;
  assign halt                 = misaligned;
  assign bus.fetch_misaligned = misaligned;

  always_ff @(posedge clk) begin
    if (reset)
      misaligned <= 1'b0;
    else if (bus.PcSel && (bus.BrPC[1:0] != 2'b00))
      misaligned <= 1'b1;
  end
`else
  assign halt = 1'b0;
`endif

  // Pushes are masked by a redirect; the head is hidden while a redirect is flushing it.
  assign push        = (state == WAIT) && bus.imem_rvalid && !bus.PcSel;
  assign bus.if_valid = !empty && !bus.PcSel;
  assign pop         = bus.if_valid && bus.if_ready;
  assign bus.if_pc    = empty ? '0 : fifo_pc[rd_ptr];
  assign bus.if_instr = empty ? '0 : fifo_instr[rd_ptr];

  always_comb begin
    state_nxt     = state;
    bus.imem_req  = 1'b0;
    bus.imem_addr = '0;
    accept        = 1'b0;
    if (state == FETCH && !full && !halt && !reset) begin
      bus.imem_req  = 1'b1;
      bus.imem_addr = pc;
      accept        = bus.imem_ready;
    end
    unique case (state)
      FETCH: if (accept) state_nxt = bus.PcSel ? DROP : WAIT;
      WAIT: begin
        if (bus.imem_rvalid)  state_nxt = FETCH;
        else if (bus.PcSel)   state_nxt = DROP;
      end
      DROP: if (bus.imem_rvalid) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    // A request still in flight at reset must have its response swallowed afterwards.
    if (reset)
      state_nxt = ((state == WAIT || state == DROP) && !bus.imem_rvalid) ? DROP : FETCH;
  end

  always_ff @(posedge clk) begin
    state <= state_nxt;
    if (reset) begin
      pc     <= RESET_PC;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (bus.PcSel) begin
      pc     <= target;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc     <= pc + PC_W'(4);
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= pc;
      fifo_instr[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Bench for fetch_redirect_unit: queue-based fetch model compared every cycle, directed scenarios
// with literal expectations, and a short randomised stretch.
module tb_fetch_redirect_unit;
  localparam int PC_W  = 9;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_redirect_if #(.PC_W(PC_W)) bus ();

  fetch_redirect_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // model state: outst 0 = nothing in flight, 1 = live request, 2 = stale request
  ent_t            q[$];
  logic [PC_W-1:0] mpc;
  int              outst;
  bit              halted, misal, known;
  // memory responder
  bit              mem_ready, pend;
  int              lat, pend_cnt;
  logic [PC_W-1:0] pend_addr;
  // observation logs
  logic [PC_W-1:0] acc_log[$];
  logic [PC_W-1:0] pop_log[$];
  int              cyc, first_acc_cyc, first_valid_cyc;
  int              n_checks, n_fail;

  function automatic logic [31:0] mem_word(input logic [PC_W-1:0] a);
    return {16'hA5C3, 7'b0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
    cyc = 0;
    first_acc_cyc = -1;
    first_valid_cyc = -1;
  endtask

  task automatic cycle();
    logic            exp_req, exp_valid, acc, pop, rv, misb;
    logic [PC_W-1:0] exp_addr, epc;
    logic [31:0]     einstr;
    ent_t            e;
    rv = pend && (pend_cnt <= 1);
    bus.imem_rvalid = rv;
    bus.imem_rdata  = rv ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    bus.imem_ready  = mem_ready;
    @(negedge clk);
    exp_req   = !reset && (outst == 0) && (q.size() < DEPTH) && !halted;
    exp_addr  = exp_req ? mpc : '0;
    exp_valid = (q.size() > 0) && !bus.PcSel;
    epc       = (q.size() > 0) ? q[0].pc : '0;
    einstr    = (q.size() > 0) ? q[0].instr : '0;
    if (known) begin
      check("imem_req", 32'(bus.imem_req), 32'(exp_req));
      check("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
      check("if_valid", 32'(bus.if_valid), 32'(exp_valid));
      check("if_pc", 32'(bus.if_pc), 32'(epc));
      check("if_instr", bus.if_instr, einstr);
`ifdef FETCH_MISALIGN_CHK_EN
      check("fetch_misaligned", 32'(bus.fetch_misaligned), 32'(misal));
`endif
    end
    acc = exp_req && mem_ready;
    pop = exp_valid && bus.if_ready;
    if (known && exp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (acc && first_acc_cyc < 0) first_acc_cyc = cyc;
    @(posedge clk);
    if (reset) begin
      q.delete();
      mpc    = '0;
      outst  = (outst != 0 && !rv) ? 2 : 0;
      halted = 1'b0;
      misal  = 1'b0;
      known  = 1'b1;
    end else if (bus.PcSel) begin
      q.delete();
      mpc = PC_W'(bus.BrPC & 32'hFFFF_FFFC);
      misb = (bus.BrPC % 4) != 0;
`ifdef FETCH_MISALIGN_CHK_EN
      if (misb) begin
        halted = 1'b1;
        misal  = 1'b1;
      end
`endif
      if (acc) outst = 2;
      else     outst = (outst != 0 && !rv) ? 2 : 0;
    end else begin
      if (pop) void'(q.pop_front());
      if (rv) begin
        if (outst == 1) begin
          e.pc    = mpc;
          e.instr = bus.imem_rdata;
          q.push_back(e);
          mpc = mpc + 4;
        end
        outst = 0;
      end
      if (acc) outst = 1;
    end
    if (rv) pend = 1'b0;
    else if (pend) pend_cnt--;
    if (acc) begin
      pend      = 1'b1;
      pend_cnt  = lat;
      pend_addr = exp_addr;
      acc_log.push_back(exp_addr);
    end
    if (pop) pop_log.push_back(epc);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) cycle();
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_if_pc", 32'(bus.if_pc), 32'd0);
    check("rst_if_instr", bus.if_instr, 32'd0);
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    n_checks = 0; n_fail = 0;
    reset = 1'b1; bus.PcSel = 1'b0; bus.BrPC = '0; bus.if_ready = 1'b0;
    bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    mem_ready = 1'b1; lat = 1; pend = 1'b0; pend_cnt = 0; pend_addr = '0;
    mpc = '0; outst = 0; halted = 1'b0; misal = 1'b0; known = 1'b0;
    clear_logs();
    #1;

    // straight-line fetch, decode always ready
    do_reset(2);
    bus.if_ready = 1'b1;
    repeat (9) cycle();
    check("s1_acc0", 32'(acc_log[0]), 32'h0);
    check("s1_acc1", 32'(acc_log[1]), 32'h4);
    check("s1_acc2", 32'(acc_log[2]), 32'h8);
    check("s1_acc3", 32'(acc_log[3]), 32'hC);
    check("s1_pop0", 32'(pop_log[0]), 32'h0);
    check("s1_pop3", 32'(pop_log[3]), 32'hC);
    check("s1_first_valid_latency", 32'(first_valid_cyc - first_acc_cyc), 32'd2);

    // decode stalled until the buffer fills, then drained
    do_reset(1);
    bus.if_ready = 1'b0;
    repeat (10) cycle();
    check("s2_buffered", 32'(q.size()), 32'd4);
    check("s2_accepts", 32'(acc_log.size()), 32'd4);
    check("s2_req_when_full", 32'(bus.imem_req), 32'd0);
    clear_logs();
    bus.if_ready = 1'b1;
    repeat (12) cycle();
    check("s2_pop0", 32'(pop_log[0]), 32'h0);
    check("s2_pop1", 32'(pop_log[1]), 32'h4);
    check("s2_pop2", 32'(pop_log[2]), 32'h8);
    check("s2_pop3", 32'(pop_log[3]), 32'hC);
    check("s2_pop4", 32'(pop_log[4]), 32'h10);
    check("s2_resume_addr", 32'(acc_log[0]), 32'h10);

    // redirect while waiting on addr 8
    do_reset(1);
    lat = 2;
    g = 0;
    while (!(acc_log.size() > 0 && acc_log[acc_log.size()-1] == 9'h8) && g < 30) begin
      cycle();
      g++;
    end
    check("s3_reached_addr8", 32'(g < 30), 32'd1);
    bus.PcSel = 1'b1; bus.BrPC = 32'h40;
    cycle();
    bus.PcSel = 1'b0;
    check("s3_flushed", 32'(q.size()), 32'd0);
    clear_logs();
    repeat (10) cycle();
    check("s3_next_req", 32'(acc_log[0]), 32'h40);
    check("s3_first_pop", 32'(pop_log[0]), 32'h40);
    bus.PcSel = 1'b1; bus.BrPC = 32'h80;
    cycle();
    bus.BrPC = 32'hC0;
    cycle();
    bus.PcSel = 1'b0;
    clear_logs();
    repeat (6) cycle();
    check("s3_b2b_last_wins", 32'(acc_log[0]), 32'hC0);

    // redirect in the same cycle as rvalid, decode stalled
    do_reset(1);
    lat = 1;
    bus.if_ready = 1'b0;
    repeat (3) cycle();
    check("s4_pending_addr", 32'(pend_addr), 32'h4);
    check("s4_one_buffered", 32'(q.size()), 32'd1);
    bus.PcSel = 1'b1; bus.BrPC = 32'h20;
    #1;
    check("s4_valid_forced_low", 32'(bus.if_valid), 32'd0);
    cycle();
    bus.PcSel = 1'b0;
    check("s4_no_push", 32'(q.size()), 32'd0);
    clear_logs();
    repeat (4) cycle();
    check("s4_next_req", 32'(acc_log[0]), 32'h20);

    // pc wrap at the top of the address space, upper BrPC bits ignored
    do_reset(1);
    bus.if_ready = 1'b1;
    bus.PcSel = 1'b1; bus.BrPC = 32'hFFFF_F1FC;
    cycle();
    bus.PcSel = 1'b0;
    clear_logs();
    repeat (8) cycle();
    check("s5_acc_top", 32'(acc_log[0]), 32'h1FC);
    check("s5_acc_wrap", 32'(acc_log[1]), 32'h0);
    check("s5_pop_top", 32'(pop_log[0]), 32'h1FC);
    check("s5_pop_wrap", 32'(pop_log[1]), 32'h0);

    // misaligned redirect target
    do_reset(1);
    bus.PcSel = 1'b1; bus.BrPC = 32'h42;
    cycle();
    bus.PcSel = 1'b0;
    clear_logs();
    repeat (8) cycle();
`ifdef FETCH_MISALIGN_CHK_EN
    check("s6_no_fetch", 32'(acc_log.size()), 32'd0);
    check("s6_flag", 32'(bus.fetch_misaligned), 32'd1);
    check("s6_req_low", 32'(bus.imem_req), 32'd0);
    do_reset(1);
    check("s6_flag_cleared", 32'(bus.fetch_misaligned), 32'd0);
    check("s6_req_resumes", 32'(bus.imem_req), 32'd1);
`else
    check("s6_aligned_target", 32'(acc_log[0]), 32'h40);
`endif

    // reset while a request is in flight: its late response must be dropped
    do_reset(1);
    lat = 3;
    mem_ready = 1'b0;
    bus.PcSel = 1'b1; bus.BrPC = 32'h100;
    cycle();
    bus.PcSel = 1'b0;
    mem_ready = 1'b1;
    cycle();
    check("s7_inflight_addr", 32'(pend_addr), 32'h100);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    clear_logs();
    repeat (12) cycle();
    check("s7_first_acc_cycle", 32'(first_acc_cyc), 32'd2);
    check("s7_acc0", 32'(acc_log[0]), 32'h0);
    check("s7_pop0", 32'(pop_log[0]), 32'h0);

    // randomised stretch, checked by the per-cycle model comparison
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      bus.if_ready = ($urandom_range(0, 3) != 0);
      mem_ready    = ($urandom_range(0, 2) != 0);
      lat          = $urandom_range(1, 3);
      bus.PcSel    = ($urandom_range(0, 15) == 0);
`ifdef FETCH_MISALIGN_CHK_EN
      bus.BrPC     = $urandom & 32'hFFFF_FFFC;
`else
      bus.BrPC     = $urandom;
`endif
      reset        = ($urandom_range(0, 99) == 0);
      cycle();
    end
    bus.PcSel = 1'b0;
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
